// File: rtl/rca_adder_16bit_if.sv
// -----------------------------------------------------------------------------
// rca_adder_16bit_if
// Operand/result bundle for the ripple-carry adder stage.
//
// Signals:
//   in_valid  : operands a/b are valid this cycle (master -> slave)
//   a, b      : unsigned operands, WIDTH bits       (master -> slave)
//   sum       : registered (a+b) mod 2^WIDTH        (slave -> master)
//   cout      : registered carry out of the MSB     (slave -> master)
//   out_valid : sum/cout hold a freshly captured result (slave -> master)
//
// Modports:
//   master : the block that supplies operands and consumes results
//   slave  : the adder itself
// -----------------------------------------------------------------------------
interface rca_adder_16bit_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             out_valid;

    modport master (
        output in_valid,
        output a,
        output b,
        input  sum,
        input  cout,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        output sum,
        output cout,
        output out_valid
    );
endinterface

// File: rtl/rca_adder_16bit.sv
// -----------------------------------------------------------------------------
// rca_adder_16bit
// Unsigned ripple-carry adder with a registered result; accumulate/add stage
// of the FIR datapath. The sum is built from an explicit chain of 1-bit full
// adders, carry rippling from bit 0 up to bit WIDTH-1, with no carry-in.
//
// Ports:
//   clk   : system clock, rising edge active
//   rst_n : asynchronous reset, active low; clears sum/cout/out_valid at once
//   bus   : slave side of rca_adder_16bit_if
//             in_valid, a, b        -> operands sampled on the rising edge
//             sum, cout, out_valid  <- registered result, 1-cycle latency
//
// When in_valid is low the result registers hold their last value and only
// out_valid drops, so downstream logic can keep reading the previous sum.
// All outputs come straight from flops; there is no combinational path from
// operands to outputs.
// -----------------------------------------------------------------------------
module rca_adder_16bit #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rca_adder_16bit_if.slave     bus
);

    // Ripple chain: w_carry[0] is the (absent) carry-in, tied to zero.
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_out_valid;

    assign w_carry[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_full_adder
            logic w_a;
            logic w_b;
            logic w_c;

            assign w_a = bus.a[gi];
            assign w_b = bus.b[gi];
            assign w_c = w_carry[gi];

            assign w_sum[gi]      = w_a ^ w_b ^ w_c;
            assign w_carry[gi+1]  = (w_a & w_b) | (w_a & w_c) | (w_b & w_c);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_carry[WIDTH];
            end
        end
    end

    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_rca_adder_16bit.sv
module tb_rca_adder_16bit;

    localparam int WIDTH = 16;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    // Scoreboard of expected {cout, sum} for every valid operand pair driven.
    logic [WIDTH:0] exp_q[$];
    // Value the result registers should be holding when no new result arrives.
    logic [WIDTH:0] exp_hold;

    rca_adder_16bit_if #(.WIDTH(WIDTH)) intf ();

    rca_adder_16bit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (intf.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of operands, then check the registered outputs just
    // after the capturing edge.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] av,
                         input logic [WIDTH-1:0] bv, input bit verbose);
        logic [WIDTH:0] e;
        @(negedge clk);
        intf.in_valid = v;
        intf.a        = av;
        intf.b        = bv;
        if (v) exp_q.push_back({1'b0, av} + {1'b0, bv});
        @(posedge clk);
        #1;
        chk("out_valid", {31'd0, intf.out_valid}, {31'd0, v});
        if (v) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_nonempty", 32'd0, 32'd1);
                e = exp_hold;
            end else begin
                e = exp_q.pop_front();
            end
            exp_hold = e;
        end
        chk(v ? "sum" : "sum_hold", {16'd0, intf.sum}, {16'd0, exp_hold[WIDTH-1:0]});
        chk(v ? "cout" : "cout_hold", {31'd0, intf.cout}, {31'd0, exp_hold[WIDTH]});
        if (verbose)
            $display("txn v=%0d a=%0d b=%0d -> sum=%0d cout=%0d out_valid=%0d",
                     v, av, bv, intf.sum, intf.cout, intf.out_valid);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        exp_hold      = '0;
        intf.in_valid = 1'b0;
        intf.a        = '0;
        intf.b        = '0;

        // Asynchronous reset before any clock edge.
        rst_n = 1'b0;
        #2;
        chk("reset_sum", {16'd0, intf.sum}, 32'd0);
        chk("reset_cout", {31'd0, intf.cout}, 32'd0);
        chk("reset_out_valid", {31'd0, intf.out_valid}, 32'd0);

        // A valid input while reset is held must not be captured.
        @(negedge clk);
        intf.in_valid = 1'b1;
        intf.a        = 16'd5;
        intf.b        = 16'd6;
        @(posedge clk);
        #1;
        chk("reset_hold_sum", {16'd0, intf.sum}, 32'd0);
        chk("reset_hold_valid", {31'd0, intf.out_valid}, 32'd0);
        @(negedge clk);
        intf.in_valid = 1'b0;
        rst_n = 1'b1;

        // Directed steps.
        cycle(1'b1, 16'd0, 16'd0, 1'b1);
        cycle(1'b1, 16'd40000, 16'd6000, 1'b1);
        cycle(1'b1, 16'd17380, 16'd9700, 1'b1);
        cycle(1'b1, 16'd5654, 16'd16662, 1'b1);
        cycle(1'b1, 16'd65535, 16'd1, 1'b1);
        cycle(1'b1, 16'd65535, 16'd65535, 1'b1);
        cycle(1'b1, 16'd100, 16'd200, 1'b1);
        cycle(1'b0, 16'd1234, 16'd4321, 1'b1);
        cycle(1'b0, 16'd65535, 16'd65535, 1'b1);
        chk("hold_300", {16'd0, intf.sum}, 32'd300);

        // Mid-cycle asynchronous reset after a result of 46000, with a
        // valid operand pair in flight that must be discarded.
        cycle(1'b1, 16'd40000, 16'd6000, 1'b1);
        @(negedge clk);
        intf.in_valid = 1'b1;
        intf.a        = 16'd7;
        intf.b        = 16'd8;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_sum", {16'd0, intf.sum}, 32'd0);
        chk("midreset_cout", {31'd0, intf.cout}, 32'd0);
        chk("midreset_out_valid", {31'd0, intf.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("midreset_edge_sum", {16'd0, intf.sum}, 32'd0);
        @(negedge clk);
        intf.in_valid = 1'b0;
        rst_n = 1'b1;
        exp_hold = '0;
        exp_q.delete();
        $display("txn async reset applied and released");
        cycle(1'b1, 16'd1, 16'd2, 1'b1);
        chk("post_reset_3", {16'd0, intf.sum}, 32'd3);

        // Random operands with random in_valid.
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'b0);
        end
        $display("txn random block of 10000 cycles done");

        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
